// File: rtl/input_port_conditioner.sv
// -----------------------------------------------------------------------------
// input_port_conditioner
//
// Conditions the external input pins of the MIPS32 system before they reach
// the memory-mapped port decoder. Pin i is read by the CPU at address 8+i.
// Each pin goes through three stages:
//   1. A two-flop synchronizer that brings the asynchronous pin into clk.
//   2. A counter-based debouncer. A new level is accepted only after the
//      synchronized pin has disagreed with the current level for
//      DEBOUNCE_CYCLES consecutive edges.
//   3. A sticky rising-edge flag. It sets when the debounced level goes 0->1
//      and clears when the CPU reads that pin's address.
//
// Parameters:
//   NUM_IN           number of input pins (pin i maps to address 8+i)
//   DEBOUNCE_CYCLES  consecutive disagreeing edges needed to accept a new
//                    level, legal range 1..255
//
// Ports:
//   clk         in   1       system clock, rising-edge active
//   rst_n       in   1       asynchronous active-low reset
//   rawPins     in   NUM_IN  asynchronous external pins
//   dirSelect   in   8       data-memory address from the ALU path
//   selectRead  in   1       decoder is returning an input-port value
//   inputPorts  out  NUM_IN  debounced, synchronized pin levels
//   edgeFlags   out  NUM_IN  sticky rising-edge flags, one per pin
//   anyEdge     out  1       OR of all edge flags
// -----------------------------------------------------------------------------
module input_port_conditioner #(
  parameter int NUM_IN          = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] rawPins,
  input  logic [7:0]        dirSelect,
  input  logic              selectRead,
  output logic [NUM_IN-1:0] inputPorts,
  output logic [NUM_IN-1:0] edgeFlags,
  output logic              anyEdge
);

  // Address of pin 0 in the data-memory map; pin i sits at BASE_ADDR+i.
  localparam int          BASE_ADDR = 8;
  // Terminal count of the debouncer. Reaching it while still disagreeing
  // accepts the new level, so the counter never passes this value.
  localparam logic [7:0]  CNT_LAST  = 8'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_IN-1:0] sync1;
  logic [NUM_IN-1:0] sync2;
  logic [NUM_IN-1:0] stable;
  logic [NUM_IN-1:0] flags;
  logic [7:0]        cnt [NUM_IN];

  // ---------------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------------
  logic [NUM_IN-1:0] stableNext;
  logic [NUM_IN-1:0] flagsNext;
  logic [NUM_IN-1:0] riseEvent;
  logic [NUM_IN-1:0] readHit;
  logic [7:0]        cntNext [NUM_IN];

  // Debouncer: compare the synchronized pin against the accepted level.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    stableNext = stable;
    for (int i = 0; i < NUM_IN; i++) begin
      cntNext[i] = '0;
    end

    for (int i = 0; i < NUM_IN; i++) begin
      if (sync2[i] == stable[i]) begin
        // Any agreeing edge restarts the disagreement count.
        cntNext[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        stableNext[i] = sync2[i];
        cntNext[i]    = '0;
      end else begin
        cntNext[i] = cnt[i] + 8'd1;
      end
    end
  end

  // Edge flags: set on an accepted 0->1 transition, clear on a read of the
  // pin's own address. Setting wins over clearing so a rising edge that
  // coincides with the read is not lost.
  always_comb begin
    riseEvent = '0;
    readHit   = '0;
    flagsNext = flags;

    for (int i = 0; i < NUM_IN; i++) begin
      riseEvent[i] = ~stable[i] & stableNext[i];
      readHit[i]   = selectRead && (dirSelect == 8'(BASE_ADDR + i));
      flagsNext[i] = riseEvent[i] | (flags[i] & ~readHit[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      flags  <= '0;
      // NOTE: the counter array is flop-based and small, so every entry is
      // reset; an abandoned partial count must not survive a reset.
      for (int i = 0; i < NUM_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments here let sync2 take the old sync1,
      // giving a true two-stage synchronizer regardless of statement order.
      sync1  <= rawPins;
      sync2  <= sync1;
      stable <= stableNext;
      flags  <= flagsNext;
      for (int i = 0; i < NUM_IN; i++) begin
        cnt[i] <= cntNext[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign inputPorts = stable;
  assign edgeFlags  = flags;
  // Straight from the flag registers, so it tracks edgeFlags with no lag.
  assign anyEdge    = |flags;

endmodule

// File: tb/tb_input_port_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_port_conditioner
//
// Directed bench for input_port_conditioner with default parameters
// (NUM_IN = 2, DEBOUNCE_CYCLES = 4). A table of per-cycle records covers
// acceptance, read-clear decoding, falling edges, glitch rejection and the
// set/clear collision. Hand-written sequences cover the asynchronous reset
// and a reset landing in the middle of a count.
// -----------------------------------------------------------------------------
module tb_input_port_conditioner;

  localparam int NUM_IN = 2;

  logic              clk;
  logic              rst_n;
  logic [NUM_IN-1:0] rawPins;
  logic [7:0]        dirSelect;
  logic              selectRead;
  logic [NUM_IN-1:0] inputPorts;
  logic [NUM_IN-1:0] edgeFlags;
  logic              anyEdge;

  int checks;
  int errors;

  input_port_conditioner #(
    .NUM_IN         (NUM_IN),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rawPins   (rawPins),
    .dirSelect (dirSelect),
    .selectRead(selectRead),
    .inputPorts(inputPorts),
    .edgeFlags (edgeFlags),
    .anyEdge   (anyEdge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock: inputs applied before the edge, outputs expected
  // just after it.
  typedef struct {
    logic [1:0] raw;
    logic       sel;
    logic [7:0] dir;
    logic [1:0] expPorts;
    logic [1:0] expFlags;
    logic       expAny;
  } VecRec;

  VecRec vecs[$];

  function automatic void add(input logic [1:0] raw, input logic sel,
                              input logic [7:0] dir, input logic [1:0] ports,
                              input logic [1:0] flagsExp, input logic any);
    VecRec v;
    v.raw      = raw;
    v.sel      = sel;
    v.dir      = dir;
    v.expPorts = ports;
    v.expFlags = flagsExp;
    v.expAny   = any;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOuts(input string tag, input logic [1:0] ports,
                           input logic [1:0] flagsExp, input logic any);
    check({tag, ".inputPorts"}, 32'(inputPorts), 32'(ports));
    check({tag, ".edgeFlags"},  32'(edgeFlags),  32'(flagsExp));
    check({tag, ".anyEdge"},    32'(anyEdge),    32'(any));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    rawPins    = '0;
    dirSelect  = '0;
    selectRead = 1'b0;

    // -------------------------------------------------------------------------
    // Vector table. Row k is applied before edge k after reset release.
    // -------------------------------------------------------------------------
    // Both pins high: accepted on the 6th edge (2 sync + 4 count).
    for (int i = 0; i < 5; i++) add(2'b11, 1'b0, 8'd0, 2'b00, 2'b00, 1'b0);
    add(2'b11, 1'b0, 8'd0,  2'b11, 2'b11, 1'b1);
    // Read-clear decode: 10 is out of range, 8 clears only pin 0, 9 clears pin 1.
    add(2'b11, 1'b1, 8'd10, 2'b11, 2'b11, 1'b1);
    add(2'b11, 1'b1, 8'd8,  2'b11, 2'b10, 1'b1);
    add(2'b11, 1'b1, 8'd9,  2'b11, 2'b00, 1'b0);
    add(2'b11, 1'b0, 8'd9,  2'b11, 2'b00, 1'b0);
    // Both pins fall: level drops 6 edges later, flags stay clear.
    for (int i = 0; i < 5; i++) add(2'b00, 1'b0, 8'd0, 2'b11, 2'b00, 1'b0);
    add(2'b00, 1'b0, 8'd0,  2'b00, 2'b00, 1'b0);
    // 3-cycle glitch on pin 0 is rejected.
    for (int i = 0; i < 3; i++) add(2'b01, 1'b0, 8'd0, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) add(2'b00, 1'b0, 8'd0, 2'b00, 2'b00, 1'b0);
    // 4-cycle pulse on pin 0 is accepted on the 6th edge; the read of
    // address 8 lands on that same edge and the set wins.
    for (int i = 0; i < 4; i++) add(2'b01, 1'b0, 8'd0, 2'b00, 2'b00, 1'b0);
    add(2'b00, 1'b0, 8'd0,  2'b00, 2'b00, 1'b0);
    add(2'b00, 1'b1, 8'd8,  2'b01, 2'b01, 1'b1);
    // High for exactly 4 cycles, then the symmetric fall.
    for (int i = 0; i < 3; i++) add(2'b00, 1'b0, 8'd0, 2'b01, 2'b01, 1'b1);
    add(2'b00, 1'b0, 8'd0,  2'b00, 2'b01, 1'b1);
    // Held read strobe: first clears pin 0, pin-1 address touches nothing set.
    add(2'b00, 1'b1, 8'd8,  2'b00, 2'b00, 1'b0);
    add(2'b00, 1'b1, 8'd9,  2'b00, 2'b00, 1'b0);

    // Reset state, checked while still in reset.
    #12;
    checkOuts("reset", 2'b00, 2'b00, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      rawPins    = vecs[k].raw;
      selectRead = vecs[k].sel;
      dirSelect  = vecs[k].dir;
      tick();
      checkOuts($sformatf("vec%0d", k), vecs[k].expPorts, vecs[k].expFlags,
                vecs[k].expAny);
    end
    selectRead = 1'b0;
    dirSelect  = '0;

    // -------------------------------------------------------------------------
    // Asynchronous reset mid-cycle with both pins high and accepted.
    // -------------------------------------------------------------------------
    rawPins = 2'b11;
    for (int i = 0; i < 6; i++) tick();
    checkOuts("preAsync", 2'b11, 2'b11, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    // Still well before the next rising edge: reset must already have acted.
    checkOuts("asyncReset", 2'b00, 2'b00, 1'b0);
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOuts($sformatf("postRelease%0d", i), 2'b00, 2'b00, 1'b0);
    end
    tick();
    checkOuts("postRelease6", 2'b11, 2'b11, 1'b1);

    // -------------------------------------------------------------------------
    // Reset landing in the middle of a count on pin 0.
    // -------------------------------------------------------------------------
    rawPins = 2'b00;
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    rawPins = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    check("midCount.noEarly", 32'(inputPorts), 32'h0);
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOuts($sformatf("midCount%0d", i), 2'b00, 2'b00, 1'b0);
    end
    tick();
    checkOuts("midCount6", 2'b01, 2'b01, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
